// File: rtl/cbrt_arbiter_if.sv
// Client and core handshake bundle for the shared cube-root arbiter.
// The slave modport is the arbiter's view; master is the surrounding clients and core.
interface cbrt_arbiter_if #(
  parameter int N_REQ = 2,
  parameter int W     = 16
);
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] x_in;
  logic [N_REQ-1:0]   ack;
  logic [W-1:0]       y_out;
  logic               err;
  logic [1:0]         grant_id;
  logic               arb_busy;
  logic               core_start;
  logic [W-1:0]       core_x;
  logic [1:0]         core_busy;
  logic [W-1:0]       core_res;

  modport slave (
    input  req, x_in, core_busy, core_res,
    output ack, y_out, err, grant_id, arb_busy, core_start, core_x
  );

  modport master (
    output req, x_in, core_busy, core_res,
    input  ack, y_out, err, grant_id, arb_busy, core_start, core_x
  );
endinterface

// File: rtl/cbrt_arbiter.sv
// Round-robin arbiter sharing one multi-cycle cube-root core between N_REQ clients,
// with a watchdog that aborts a hung core operation and reports it through err.
module cbrt_arbiter #(
  parameter int N_REQ   = 2,
  parameter int W       = 16,
  parameter int TIMEOUT = 64
) (
  input logic           clk,
  input logic           rst,
  cbrt_arbiter_if.slave bus
);

  localparam int          TW = $clog2(TIMEOUT);
  localparam int unsigned NR = N_REQ;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [1:0]    rr_ptr, grant, pick;
  logic          pick_vld;
  logic [TW-1:0] timer;
  logic [W-1:0]  x_q, y_q;
  logic          err_q;
  logic          expired, core_done;
  logic [3:0]    req_ext, ack_ext;

  assign req_ext   = 4'(bus.req);
  assign expired   = (timer == TW'(TIMEOUT - 1));
  assign core_done = (bus.core_busy == 2'b00);

  // First asserted request at or after rr_ptr, wrapping modulo N_REQ.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    pick_vld = 1'b0;
    pick     = '0;
    for (int unsigned i = 0; i < NR; i++) begin
      idx = (32'(rr_ptr) + i) % NR;
      if (!pick_vld && req_ext[2'(idx)]) begin
        pick_vld = 1'b1;
        pick     = 2'(idx);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // In WAIT the watchdog outranks a first busy indication; in RUN completion outranks it.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pick_vld) state_nx = ISSUE;
      ISSUE:   state_nx = WAIT;
      WAIT:    if (expired) state_nx = DONE;
               else if (!core_done) state_nx = RUN;
      RUN:     if (core_done || expired) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      grant  <= '0;
      timer  <= '0;
      x_q    <= '0;
      y_q    <= '0;
      err_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (pick_vld) begin
          grant <= pick;
          x_q   <= bus.x_in[32'(pick)*W +: W];
        end
        ISSUE: timer <= '0;
        WAIT, RUN: begin
          timer <= timer + 1'b1;
          if (state == RUN && core_done) begin
            y_q   <= bus.core_res;
            err_q <= 1'b0;
          end else if (expired) begin
            y_q   <= '1;
            err_q <= 1'b1;
          end
        end
        DONE: rr_ptr <= (32'(grant) == NR - 1) ? '0 : grant + 2'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    ack_ext        = (state == DONE) ? (4'b0001 << grant) : '0;
    bus.ack        = ack_ext[N_REQ-1:0];
    bus.y_out      = y_q;
    bus.err        = err_q;
    bus.grant_id   = grant;
    bus.arb_busy   = (state != IDLE);
    bus.core_start = (state == ISSUE);
    bus.core_x     = x_q;
  end

endmodule

// File: tb/tb_cbrt_arbiter.sv
// Self-checking bench for cbrt_arbiter: behavioural cube-root core plus a scoreboard
// of expected acks (client, result, error) consumed as the arbiter answers.
module tb_cbrt_arbiter;

  localparam int N_REQ    = 2;
  localparam int W        = 16;
  localparam int TIMEOUT  = 16;
  localparam int CORE_CYC = 5;

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] y;
    logic         err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;

  cbrt_arbiter_if #(.N_REQ(N_REQ), .W(W)) bus ();

  cbrt_arbiter #(.N_REQ(N_REQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  exp_t             sb[$];
  exp_t             mon_e;
  int               n_chk = 0;
  int               n_fail = 0;
  int               ack_cnt = 0;
  int               start_cnt = 0;
  logic [N_REQ-1:0] last_ack = '0;
  bit               stuck = 1'b0;
  int               core_cnt;
  logic [W-1:0]     core_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int icbrt(input int x);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Core model: busy for CORE_CYC cycles after start; result only valid as busy drops.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      core_cnt      <= 0;
      core_pend     <= '0;
      bus.core_busy <= 2'b00;
      bus.core_res  <= '0;
    end else if (bus.core_start && !stuck) begin
      bus.core_busy <= 2'b01;
      core_cnt      <= CORE_CYC - 1;
      core_pend     <= W'(icbrt(int'(bus.core_x)));
      bus.core_res  <= 16'hDEAD;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
    end else if (bus.core_busy != 2'b00) begin
      bus.core_busy <= 2'b00;
      bus.core_res  <= core_pend;
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rst === 1'b0 && bus.ack != '0) begin
      check("ack_onehot", 32'($countones(bus.ack)), 1);
      if (sb.size() == 0) begin
        check("ack_unexpected", 32'(bus.ack), 0);
      end else begin
        mon_e = sb.pop_front();
        check("ack_vec", 32'(bus.ack), 32'(1) << mon_e.id);
        check("grant_id", 32'(bus.grant_id), 32'(mon_e.id));
        check("y_out", 32'(bus.y_out), 32'(mon_e.y));
        check("err", 32'(bus.err), 32'(mon_e.err));
        check("arb_busy_at_ack", 32'(bus.arb_busy), 1);
      end
      last_ack = bus.ack;
      ack_cnt++;
    end
    if (rst === 1'b0 && bus.core_start === 1'b1) start_cnt++;
  end

  task automatic drive(input int k, input logic [W-1:0] x);
    bus.x_in[k*W +: W] = x;
    bus.req[k] = 1'b1;
  endtask

  task automatic push(input int k, input logic [W-1:0] y, input bit e);
    exp_t t;
    t.id  = 2'(k);
    t.y   = y;
    t.err = e;
    sb.push_back(t);
  endtask

  // Counts rising edges until cnt more acks appear; drop clears the served client's req.
  task automatic wait_acks(input int cnt, input int budget, input bit drop, output int n);
    int target;
    int seen;
    target = ack_cnt + cnt;
    seen   = ack_cnt;
    n      = 0;
    while (ack_cnt < target) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (ack_cnt != seen) begin
        seen = ack_cnt;
        if (drop) bus.req = bus.req & ~last_ack;
      end
      if (n > budget && ack_cnt < target) begin
        check("ack_wait", 32'(n), 32'(budget));
        break;
      end
    end
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int saved;
    rst      = 1'b1;
    bus.req  = '0;
    bus.x_in = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", 32'(bus.ack), 0);
    check("rst_y", 32'(bus.y_out), 0);
    check("rst_err", 32'(bus.err), 0);
    check("rst_gid", 32'(bus.grant_id), 0);
    check("rst_busy", 32'(bus.arb_busy), 0);
    check("rst_start", 32'(bus.core_start), 0);
    check("rst_core_x", 32'(bus.core_x), 0);
    rst = 1'b0;

    // Single request; the client registers ack on the edge after it appears.
    start_cnt = 0;
    drive(0, 16'd27);
    push(0, 16'd3, 1'b0);
    wait_acks(1, 40, 1'b1, n);
    check("t1_latency", 32'(n + 1), 32'(4 + CORE_CYC));
    repeat (2) @(negedge clk);
    check("t1_starts", 32'(start_cnt), 1);
    check("t1_ack_clear", 32'(bus.ack), 0);
    check("t1_y_hold", 32'(bus.y_out), 3);
    check("t1_idle", 32'(bus.arb_busy), 0);

    do_reset();
    drive(0, 16'd64);
    drive(1, 16'd125);
    push(0, 16'd4, 1'b0);
    push(1, 16'd5, 1'b0);
    wait_acks(2, 80, 1'b1, n);
    @(negedge clk);
    check("t2_gid_hold", 32'(bus.grant_id), 1);

    start_cnt = 0;
    drive(0, 16'd100);
    drive(1, 16'd1000);
    for (int i = 0; i < 6; i++) push(i % 2, W'(icbrt((i % 2 == 0) ? 100 : 1000)), 1'b0);
    wait_acks(6, 200, 1'b0, n);
    bus.req = '0;
    @(negedge clk);
    check("t3_starts", 32'(start_cnt), 6);

    stuck = 1'b1;
    drive(0, 16'd8);
    push(0, 16'hFFFF, 1'b1);
    wait_acks(1, 60, 1'b1, n);
    check("t4_abort_latency", 32'(n), 32'(TIMEOUT + 2));
    stuck = 1'b0;
    @(negedge clk);
    drive(0, 16'd8);
    push(0, 16'd2, 1'b0);
    wait_acks(1, 40, 1'b1, n);

    // Reset while the core is computing for client 1.
    @(negedge clk);
    drive(1, 16'd27);
    repeat (5) @(negedge clk);
    check("t5_busy_pre", 32'(bus.arb_busy), 1);
    check("t5_gid_pre", 32'(bus.grant_id), 1);
    rst = 1'b1;
    #1;
    check("t5_ack", 32'(bus.ack), 0);
    check("t5_y", 32'(bus.y_out), 0);
    check("t5_err", 32'(bus.err), 0);
    check("t5_gid", 32'(bus.grant_id), 0);
    check("t5_busy", 32'(bus.arb_busy), 0);
    check("t5_start", 32'(bus.core_start), 0);
    check("t5_core_x", 32'(bus.core_x), 0);
    bus.req = '0;
    saved = ack_cnt;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    check("t5_no_ack", 32'(ack_cnt), 32'(saved));

    drive(0, 16'd1);
    drive(1, 16'd0);
    push(0, 16'd1, 1'b0);
    push(1, 16'd0, 1'b0);
    wait_acks(2, 80, 1'b1, n);

    // Client 0 pulses req while client 1 is being served and never gets granted.
    @(negedge clk);
    drive(1, 16'hFFFF);
    push(1, 16'd40, 1'b0);
    repeat (2) @(negedge clk);
    drive(0, 16'd5);
    @(negedge clk);
    bus.req[0] = 1'b0;
    wait_acks(1, 40, 1'b1, n);
    saved = ack_cnt;
    repeat (20) @(negedge clk);
    check("t6_drop_no_ack", 32'(ack_cnt), 32'(saved));
    check("sb_drain", 32'(sb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got time %0t expected completion", $time);
    $fatal(1, "simulation time limit");
  end

endmodule
